// File: rtl/s2m_buffer_drain_dma.sv
// s2m_buffer_drain_dma
//   Drains the 16-bit stream-to-memory FIFO buffer into a memory-mapped
//   destination. Each word is popped from the buffer's read slave and then
//   written to the next halfword address through an Avalon-MM write master.
//   Software programs BASE and LENGTH through a CSR slave, starts the
//   transfer, and polls STATUS or takes a level interrupt on completion.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   csr_*             : CSR slave (2-bit word address, 1-cycle read latency)
//   fifo_read         : pop request to the buffer read slave
//   fifo_waitrequest  : buffer empty, pop not accepted this cycle
//   fifo_readdata     : buffer q (non-showahead: valid the cycle after a pop)
//   mem_address/write/writedata/waitrequest : destination write master
//   irq               : level interrupt, done & irq_en
//
// Handshakes: a transfer on either Avalon port completes in a cycle where the
// request (fifo_read / mem_write) is high and the matching waitrequest is low;
// while waitrequest is high the request and its address/data are held.
//
// CSR map: 0 BASE, 1 LENGTH, 2 CONTROL (w: b0 start, b1 abort, b2 irq_en),
//          3 STATUS ({count, 13'b0, aborted, done, busy}; w1 b1 clears).
module s2m_buffer_drain_dma #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  output logic              fifo_read,
  input  logic              fifo_waitrequest,
  input  logic [15:0]       fifo_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [15:0]       mem_writedata,
  input  logic              mem_waitrequest,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  length_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  count_q;
  logic [15:0]       wdata_q;
  logic              irq_en_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              abort_pend_q;

  logic ctrl_wr, start_pulse, abort_pulse, status_clr;
  logic do_load, do_zero_done, do_capture, do_advance, do_finish, do_abort_now;

  assign ctrl_wr     = csr_write && (csr_address == 2'd2);
  assign start_pulse = ctrl_wr && csr_writedata[0];
  assign abort_pulse = ctrl_wr && csr_writedata[1];
  assign status_clr  = csr_write && (csr_address == 2'd3) && csr_writedata[1];

  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign irq           = done_q & irq_en_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    fifo_read    = 1'b0;
    mem_write    = 1'b0;
    do_load      = 1'b0;
    do_zero_done = 1'b0;
    do_capture   = 1'b0;
    do_advance   = 1'b0;
    do_finish    = 1'b0;
    do_abort_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          if (length_q != '0) begin
            do_load = 1'b1;
            state_d = POP;
          end else begin
            do_zero_done = 1'b1;
          end
        end
      end
      POP: begin
        fifo_read = 1'b1;
        // An accepted pop cannot be undone, so abort only short-circuits
        // while the buffer is still empty; otherwise it gets latched below.
        if (!fifo_waitrequest) begin
          state_d = CAPTURE;
        end else if (abort_pulse) begin
          do_abort_now = 1'b1;
          state_d      = IDLE;
        end
      end
      CAPTURE: begin
        do_capture = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        mem_write = 1'b1;
        if (!mem_waitrequest) begin
          do_advance = 1'b1;
          if ((remaining_q == LEN_W'(1)) || abort_pend_q || abort_pulse) begin
            do_finish = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = POP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q       <= '0;
      addr_q       <= '0;
      length_q     <= '0;
      remaining_q  <= '0;
      count_q      <= '0;
      wdata_q      <= '0;
      irq_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (csr_write && (csr_address == 2'd0) && !busy_q)
        base_q <= {csr_writedata[ADDR_W-1:1], 1'b0};
      if (csr_write && (csr_address == 2'd1) && !busy_q)
        length_q <= csr_writedata[LEN_W-1:0];
      if (ctrl_wr)
        irq_en_q <= csr_writedata[2];

      // Status clear comes first so a start in the same cycle wins.
      if (status_clr) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end

      if (do_load) begin
        addr_q       <= base_q;
        remaining_q  <= length_q;
        count_q      <= '0;
        busy_q       <= 1'b1;
        done_q       <= 1'b0;
        aborted_q    <= 1'b0;
        abort_pend_q <= 1'b0;
      end
      if (do_zero_done)
        done_q <= 1'b1;

      if (abort_pulse && (state_q != IDLE) && !do_abort_now)
        abort_pend_q <= 1'b1;

      if (do_capture)
        wdata_q <= fifo_readdata;

      if (do_advance) begin
        addr_q      <= addr_q + ADDR_W'(2);
        remaining_q <= remaining_q - LEN_W'(1);
        count_q     <= count_q + LEN_W'(1);
      end

      if (do_finish) begin
        busy_q       <= 1'b0;
        done_q       <= 1'b1;
        aborted_q    <= abort_pend_q | abort_pulse;
        abort_pend_q <= 1'b0;
      end
      if (do_abort_now) begin
        busy_q       <= 1'b0;
        done_q       <= 1'b1;
        aborted_q    <= 1'b1;
        abort_pend_q <= 1'b0;
      end

      if (csr_read) begin
        case (csr_address)
          2'd0:    csr_readdata <= 32'(base_q);
          2'd1:    csr_readdata <= 32'(length_q);
          2'd2:    csr_readdata <= {29'b0, irq_en_q, 2'b0};
          default: csr_readdata <= {16'(count_q), 13'b0, aborted_q, done_q, busy_q};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_s2m_buffer_drain_dma.sv
// Bench for s2m_buffer_drain_dma: a FIFO model feeds the read slave, a
// destination model with optional stalls sinks the writes, and every write is
// compared against the transfer expected from BASE/LENGTH/data.
module tb_s2m_buffer_drain_dma;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        csr_address;
  logic              csr_write;
  logic [31:0]       csr_writedata;
  logic              csr_read;
  logic [31:0]       csr_readdata;
  logic              fifo_read;
  logic              fifo_waitrequest;
  logic [15:0]       fifo_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic [15:0]       mem_writedata;
  logic              mem_waitrequest;
  logic              irq;

  always #5 clk = ~clk;

  s2m_buffer_drain_dma #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .csr_address      (csr_address),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata),
    .csr_read         (csr_read),
    .csr_readdata     (csr_readdata),
    .fifo_read        (fifo_read),
    .fifo_waitrequest (fifo_waitrequest),
    .fifo_readdata    (fifo_readdata),
    .mem_address      (mem_address),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_waitrequest  (mem_waitrequest),
    .irq              (irq)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  int writes = 0;
  int pops_at_first_wr = 0;
  int mem_stall_pct = 0;
  int force_mem_stall = 0;
  int trickle_pct = 0;

  logic [47:0] exp_q[$];   // {address, data} of each expected write
  logic [15:0] fifo_q[$];  // words currently in the buffer
  logic [15:0] src_q[$];   // words waiting to be pushed into the buffer
  int          wr_cyc[$];  // cycle index of each accepted write

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] status_word(input int cnt, input bit ab, input bit dn, input bit bs);
    return {16'(cnt), 13'b0, ab, dn, bs};
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    logic [15:0] pend;
    bit          pend_v;
    pend   = '0;
    pend_v = 1'b0;
    if (src_q.size() > 0 && int'($urandom_range(0, 99)) < trickle_pct)
      fifo_q.push_back(src_q.pop_front());
    fifo_waitrequest = (fifo_q.size() == 0);
    if (mem_write && force_mem_stall > 0) begin
      mem_waitrequest = 1'b1;
      force_mem_stall--;
    end else begin
      mem_waitrequest = (int'($urandom_range(0, 99)) < mem_stall_pct);
    end
    if (fifo_read && !fifo_waitrequest) begin
      pend   = fifo_q.pop_front();
      pend_v = 1'b1;
      pops++;
    end
    if (mem_write) begin
      check_eq("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        check_eq("mem_address", 64'(mem_address), 64'(exp_q[0][47:16]));
        check_eq("mem_writedata", 64'(mem_writedata), 64'(exp_q[0][15:0]));
        if (!mem_waitrequest) begin
          void'(exp_q.pop_front());
          wr_cyc.push_back(cyc);
          writes++;
          if (writes == 1) pops_at_first_wr = pops;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (pend_v) fifo_readdata = pend;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    cycle();
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    cycle();
    csr_read    = 1'b0;
    d           = csr_readdata;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] s;
    int n;
    s = 32'h1;
    n = 0;
    while (s[0] && n < budget) begin
      csr_rd(2'd3, s);
      n++;
    end
    check_eq("wait_idle_busy", 64'(s[0]), 64'd0);
  endtask

  task automatic new_test();
    exp_q.delete();
    fifo_q.delete();
    src_q.delete();
    wr_cyc.delete();
    pops = 0;
    writes = 0;
    pops_at_first_wr = 0;
  endtask

  // Reference transfer: word i of the data goes to base + 2*i (mod 2^32).
  task automatic load_xfer(input logic [31:0] base, input int n, input bit preload);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      if (preload) fifo_q.push_back(d);
      else         src_q.push_back(d);
      exp_q.push_back({base + 32'(2 * i), d});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] base;
    int n, ie;
    reset = 1'b1; csr_address = '0; csr_write = 1'b0; csr_writedata = '0;
    csr_read = 1'b0; fifo_waitrequest = 1'b1; fifo_readdata = '0; mem_waitrequest = 1'b0;
    @(negedge clk);
    run(2);
    check_eq("rst_fifo_read", 64'(fifo_read), 64'd0);
    check_eq("rst_mem_write", 64'(mem_write), 64'd0);
    check_eq("rst_mem_address", 64'(mem_address), 64'd0);
    check_eq("rst_mem_writedata", 64'(mem_writedata), 64'd0);
    check_eq("rst_csr_readdata", 64'(csr_readdata), 64'd0);
    check_eq("rst_irq", 64'(irq), 64'd0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), r);
      check_eq("rst_csr_reg", 64'(r), 64'd0);
    end

    // CSR field behaviour
    csr_wr(2'd0, 32'h0000_1235); csr_rd(2'd0, r); check_eq("base_bit0", 64'(r), 64'h1234);
    csr_wr(2'd1, 32'hABCD_0005); csr_rd(2'd1, r); check_eq("length_upper", 64'(r), 64'h5);
    csr_wr(2'd2, 32'h0000_0004); csr_rd(2'd2, r); check_eq("control_rd", 64'(r), 64'h4);
    check_eq("irq_no_done", 64'(irq), 64'd0);
    csr_wr(2'd2, 32'h0);

    // Preloaded three-word transfer at 3 cycles per word
    new_test();
    fifo_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    exp_q  = '{{32'h1000, 16'hAAAA}, {32'h1002, 16'hBBBB}, {32'h1004, 16'hCCCC}};
    csr_wr(2'd0, 32'h1000); csr_wr(2'd1, 32'd3); csr_wr(2'd2, 32'h1);
    wait_idle(200);
    check_eq("t1_exp_left", 64'(exp_q.size()), 64'd0);
    check_eq("t1_writes", 64'(wr_cyc.size()), 64'd3);
    if (wr_cyc.size() == 3) begin
      check_eq("t1_gap01", 64'(wr_cyc[1] - wr_cyc[0]), 64'd3);
      check_eq("t1_gap12", 64'(wr_cyc[2] - wr_cyc[1]), 64'd3);
    end
    csr_rd(2'd3, r); check_eq("t1_status", 64'(r), 64'(status_word(3, 0, 1, 0)));

    // Empty buffer at start, late pushes; BASE/LENGTH locked while busy
    new_test();
    exp_q = '{{32'h2000, 16'h1234}, {32'h2002, 16'h5678}};
    csr_wr(2'd0, 32'h2000); csr_wr(2'd1, 32'd2); csr_wr(2'd2, 32'h1);
    csr_wr(2'd0, 32'hDEAD_0000); csr_wr(2'd1, 32'd9);
    csr_rd(2'd0, r); check_eq("t2_base_locked", 64'(r), 64'h2000);
    csr_rd(2'd1, r); check_eq("t2_len_locked", 64'(r), 64'd2);
    run(6);
    check_eq("t2_read_held", 64'(fifo_read), 64'd1);
    check_eq("t2_no_write", 64'(writes), 64'd0);
    fifo_q.push_back(16'h1234);
    run(20);
    check_eq("t2_one_write", 64'(writes), 64'd1);
    check_eq("t2_read_held2", 64'(fifo_read), 64'd1);
    fifo_q.push_back(16'h5678);
    wait_idle(200);
    check_eq("t2_exp_left", 64'(exp_q.size()), 64'd0);
    csr_rd(2'd3, r); check_eq("t2_status", 64'(r), 64'(status_word(2, 0, 1, 0)));

    // Destination stalls the first write for 5 cycles
    new_test();
    load_xfer(32'h3000, 2, 1'b1);
    force_mem_stall = 5;
    csr_wr(2'd0, 32'h3000); csr_wr(2'd1, 32'd2); csr_wr(2'd2, 32'h1);
    wait_idle(200);
    check_eq("t3_pops_at_wr1", 64'(pops_at_first_wr), 64'd1);
    check_eq("t3_exp_left", 64'(exp_q.size()), 64'd0);
    if (wr_cyc.size() == 2) check_eq("t3_gap", 64'(wr_cyc[1] - wr_cyc[0]), 64'd3);

    // Abort during the write of word 2
    new_test();
    load_xfer(32'h4000, 2, 1'b1);
    fifo_q.push_back(16'h0F0F); fifo_q.push_back(16'hF0F0);
    csr_wr(2'd0, 32'h4000); csr_wr(2'd1, 32'd4); csr_wr(2'd2, 32'h5);
    n = 0;
    while (!(writes == 1 && mem_write) && n < 100) begin cycle(); n++; end
    check_eq("t4_reached_write2", 64'(mem_write), 64'd1);
    csr_wr(2'd2, 32'h6);
    wait_idle(100);
    run(4);
    check_eq("t4_writes", 64'(writes), 64'd2);
    check_eq("t4_fifo_left", 64'(fifo_q.size()), 64'd2);
    csr_rd(2'd3, r); check_eq("t4_status", 64'(r), 64'(status_word(2, 1, 1, 0)));
    check_eq("t4_irq", 64'(irq), 64'd1);
    csr_wr(2'd3, 32'h2);
    check_eq("t4_irq_clr", 64'(irq), 64'd0);
    csr_rd(2'd3, r); check_eq("t4_status_clr", 64'(r), 64'(status_word(2, 0, 0, 0)));

    // Abort while waiting on an empty buffer
    new_test();
    csr_wr(2'd1, 32'd3); csr_wr(2'd2, 32'h5);
    run(3);
    csr_wr(2'd2, 32'h6);
    csr_rd(2'd3, r); check_eq("t4b_status", 64'(r), 64'(status_word(0, 1, 1, 0)));
    check_eq("t4b_irq", 64'(irq), 64'd1);
    fifo_q = '{16'h1111, 16'h2222, 16'h3333};
    run(5);
    check_eq("t4b_no_pop", 64'(pops), 64'd0);
    check_eq("t4b_fifo_read", 64'(fifo_read), 64'd0);
    csr_wr(2'd3, 32'h2); csr_wr(2'd2, 32'h0);

    // Address wrap at the top of the address space
    new_test();
    load_xfer(32'hFFFF_FFFE, 2, 1'b1);
    csr_wr(2'd0, 32'hFFFF_FFFE); csr_wr(2'd1, 32'd2); csr_wr(2'd2, 32'h1);
    wait_idle(200);
    check_eq("t5_writes", 64'(writes), 64'd2);
    check_eq("t5_exp_left", 64'(exp_q.size()), 64'd0);

    // Randomized transfers with trickling buffer and destination stalls
    trickle_pct = 40; mem_stall_pct = 30;
    for (int it = 0; it < 8; it++) begin
      new_test();
      base = $urandom & 32'hFFFF_FFFE;
      n    = $urandom_range(1, 6);
      ie   = $urandom_range(0, 1);
      load_xfer(base, n, 1'b0);
      csr_wr(2'd0, base); csr_wr(2'd1, 32'(n)); csr_wr(2'd2, {29'b0, ie[0], 2'b01});
      wait_idle(600);
      check_eq("rnd_exp_left", 64'(exp_q.size()), 64'd0);
      csr_rd(2'd3, r); check_eq("rnd_status", 64'(r), 64'(status_word(n, 0, 1, 0)));
      check_eq("rnd_irq", 64'(irq), 64'(ie[0]));
      csr_wr(2'd3, 32'h2);
      check_eq("rnd_irq_clr", 64'(irq), 64'd0);
    end
    trickle_pct = 0; mem_stall_pct = 0;

    // Reset in the middle of a stalled write, then a zero-length start
    new_test();
    load_xfer(32'h6000, 3, 1'b1);
    force_mem_stall = 20;
    csr_wr(2'd0, 32'h6000); csr_wr(2'd1, 32'd3); csr_wr(2'd2, 32'h1);
    n = 0;
    while (!mem_write && n < 50) begin cycle(); n++; end
    check_eq("t6_in_write", 64'(mem_write), 64'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    force_mem_stall = 0;
    check_eq("t6_mem_write", 64'(mem_write), 64'd0);
    check_eq("t6_fifo_read", 64'(fifo_read), 64'd0);
    csr_rd(2'd3, r); check_eq("t6_status", 64'(r), 64'd0);
    csr_rd(2'd0, r); check_eq("t6_base", 64'(r), 64'd0);
    new_test();
    csr_wr(2'd1, 32'd0); csr_wr(2'd2, 32'h1);
    check_eq("t6_zl_fifo_read", 64'(fifo_read), 64'd0);
    csr_rd(2'd3, r); check_eq("t6_zl_status", 64'(r), 64'(status_word(0, 0, 1, 0)));
    run(3);
    check_eq("t6_zl_pops", 64'(pops), 64'd0);
    check_eq("t6_zl_writes", 64'(writes), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
